// File: rtl/char_pkg.sv
// Shared definitions for the character motion block: FSM encoding,
// velocity width and the default physics constants.
package char_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_JUMP = 2'd2,
    ST_FALL = 2'd3
  } mstate_t;

  localparam int POS_W = 10;
  localparam int VY_W  = 8;

  localparam logic [POS_W-1:0] X_START_D  = 10'd32;
  localparam logic [POS_W-1:0] X_MAX_D    = 10'd928;
  localparam logic [POS_W-1:0] GROUND_Y_D = 10'd400;
  localparam int               WALK_V_D   = 2;
  localparam int               JUMP_V_D   = -12;
  localparam int               MAX_FALL_D = 8;

endpackage

// File: rtl/jump_latch.sv
// Captures rising edges of the jump button and holds them until the next
// frame tick consumes them, so short presses between frames are not lost.
module jump_latch (
  input  logic sys_clk,
  input  logic rst,
  input  logic btn_jump,
  input  logic consume,
  output logic pending
);

  logic r_btn_d;
  logic r_pending;

  // A button held through reset must not register as a fresh press afterwards.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_btn_d   <= btn_jump;
      r_pending <= 1'b0;
    end else begin
      r_btn_d <= btn_jump;
      if (btn_jump && !r_btn_d)
        r_pending <= 1'b1;
      else if (consume)
        r_pending <= 1'b0;
    end
  end

  assign pending = r_pending;

endmodule

// File: rtl/char_motion.sv
// Per-frame character physics: walking with edge clamping, jump/fall
// ballistics with saturated fall speed, and ground landing.
module char_motion
  import char_pkg::*;
#(
  parameter logic [9:0] X_START  = X_START_D,
  parameter logic [9:0] X_MAX    = X_MAX_D,
  parameter logic [9:0] GROUND_Y = GROUND_Y_D,
  parameter int         WALK_V   = WALK_V_D,
  parameter int         JUMP_V   = JUMP_V_D,
  parameter int         MAX_FALL = MAX_FALL_D
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [9:0] char_X,
  output logic [9:0] char_Y,
  output logic       facing,
  output logic       on_ground,
  output logic [1:0] mstate
);

  localparam logic signed [11:0]   C_WALK   = 12'(WALK_V);
  localparam logic signed [11:0]   C_XMAX   = $signed({2'b00, X_MAX});
  localparam logic signed [11:0]   C_GROUND = $signed({2'b00, GROUND_Y});
  localparam logic signed [VY_W-1:0] C_JUMP = VY_W'(JUMP_V);
  localparam logic signed [VY_W:0] C_ONE    = (VY_W+1)'(1);
  localparam logic signed [VY_W:0] C_MAXF   = (VY_W+1)'(MAX_FALL);

  function automatic logic [9:0] clamp_x(input logic signed [11:0] v);
    if (v < 12'sd0)  return 10'd0;
    if (v > C_XMAX)  return X_MAX;
    return v[9:0];
  endfunction

  function automatic logic signed [VY_W-1:0] sat_fall(input logic signed [VY_W-1:0] v);
    logic signed [VY_W:0] inc;
    inc = $signed({v[VY_W-1], v}) + C_ONE;
    if (inc > C_MAXF) return C_MAXF[VY_W-1:0];
    return inc[VY_W-1:0];
  endfunction

  logic                   w_pending;
  mstate_t                r_state, w_state_nx;
  logic [9:0]             r_x, w_x_nx;
  logic [9:0]             r_y, w_y_nx;
  logic signed [VY_W-1:0] r_vy, w_vy_nx;
  logic                   r_facing, w_facing_nx;
  logic                   w_left_only, w_right_only, w_one_dir;
  logic signed [11:0]     w_x_ext, w_y_sum;
  logic signed [VY_W-1:0] w_vy_sat;

  jump_latch u_jump_latch (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .btn_jump (btn_jump),
    .consume  (frame_tick),
    .pending  (w_pending)
  );

  assign w_left_only  = btn_left & ~btn_right;
  assign w_right_only = btn_right & ~btn_left;
  assign w_one_dir    = w_left_only | w_right_only;
  assign w_x_ext      = $signed({2'b00, r_x});
  assign w_y_sum      = $signed({2'b00, r_y}) + $signed({{(12-VY_W){r_vy[VY_W-1]}}, r_vy});
  assign w_vy_sat     = sat_fall(r_vy);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_x      <= X_START;
      r_y      <= GROUND_Y;
      r_vy     <= '0;
      r_facing <= 1'b1;
    end else begin
      r_state  <= w_state_nx;
      r_x      <= w_x_nx;
      r_y      <= w_y_nx;
      r_vy     <= w_vy_nx;
      r_facing <= w_facing_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_x_nx      = r_x;
    w_y_nx      = r_y;
    w_vy_nx     = r_vy;
    w_facing_nx = r_facing;
    if (frame_tick) begin
      if (w_right_only) begin
        w_x_nx      = clamp_x(w_x_ext + C_WALK);
        w_facing_nx = 1'b1;
      end else if (w_left_only) begin
        w_x_nx      = clamp_x(w_x_ext - C_WALK);
        w_facing_nx = 1'b0;
      end
      // Pending jumps are consumed every tick; only ground states act on them.
      case (r_state)
        ST_IDLE, ST_WALK: begin
          if (w_pending) begin
            w_state_nx = ST_JUMP;
            w_vy_nx    = C_JUMP;
          end else begin
            w_state_nx = w_one_dir ? ST_WALK : ST_IDLE;
          end
        end
        ST_JUMP: begin
          if (w_y_sum < 12'sd0) begin
            w_y_nx     = 10'd0;
            w_vy_nx    = '0;
            w_state_nx = ST_FALL;
          end else begin
            w_y_nx  = w_y_sum[9:0];
            w_vy_nx = w_vy_sat;
            if (!w_vy_sat[VY_W-1]) w_state_nx = ST_FALL;
          end
        end
        default: begin
          if (w_y_sum >= C_GROUND) begin
            w_y_nx     = GROUND_Y;
            w_vy_nx    = '0;
            w_state_nx = w_one_dir ? ST_WALK : ST_IDLE;
          end else begin
            w_y_nx  = w_y_sum[9:0];
            w_vy_nx = w_vy_sat;
          end
        end
      endcase
    end
  end

  assign char_X    = r_x;
  assign char_Y    = r_y;
  assign facing    = r_facing;
  assign mstate    = r_state;
  assign on_ground = (r_state == ST_IDLE) || (r_state == ST_WALK);

endmodule

// File: tb/tb_char_motion.sv
// Directed-vector bench for char_motion with hand-computed expected values.
module tb_char_motion;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_jump = 1'b0;
  logic [9:0] char_X, char_Y;
  logic       facing, on_ground;
  logic [1:0] mstate;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int IDLE = 0, WALK = 1, JUMP = 2, FALL = 3;

  char_motion dut (
    .sys_clk    (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .char_X     (char_X),
    .char_Y     (char_Y),
    .facing     (facing),
    .on_ground  (on_ground),
    .mstate     (mstate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic do_tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic jump_pulse();
    @(negedge clk); btn_jump = 1'b1;
    @(negedge clk); btn_jump = 1'b0;
  endtask

  task automatic run_jump(input bit dbl);
    string p;
    p = dbl ? "dbl" : "jmp";
    do_reset();
    @(negedge clk);
    jump_pulse();
    @(negedge clk);
    do_tick();
    chk({p, "_takeoff_state"}, mstate, JUMP);
    chk({p, "_takeoff_y"}, char_Y, 400);
    chk({p, "_takeoff_gnd"}, on_ground, 0);
    for (int k = 1; k <= 28; k++) begin
      if (dbl && (k == 5 || k == 27)) jump_pulse();
      do_tick();
      if (k == 1)  chk({p, "_y1"}, char_Y, 388);
      if (k == 11) begin
        chk({p, "_y11"}, char_Y, 323);
        chk({p, "_st11"}, mstate, JUMP);
      end
      if (k == 12) begin
        chk({p, "_apex_y"}, char_Y, 322);
        chk({p, "_apex_st"}, mstate, FALL);
      end
      if (k == 20) chk({p, "_y20"}, char_Y, 350);
      if (k == 26) begin
        chk({p, "_y26"}, char_Y, 398);
        chk({p, "_st26"}, mstate, FALL);
      end
      if (k == 27) begin
        chk({p, "_land_y"}, char_Y, 400);
        chk({p, "_land_st"}, mstate, IDLE);
        chk({p, "_land_gnd"}, on_ground, 1);
      end
      if (k == 28) chk({p, "_after_st"}, mstate, IDLE);
    end
    chk({p, "_x"}, char_X, 32);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_x", char_X, 32);
    chk("rst_y", char_Y, 400);
    chk("rst_facing", facing, 1);
    chk("rst_gnd", on_ground, 1);
    chk("rst_state", mstate, IDLE);

    // Walk right for 10 ticks, then hold between ticks
    btn_right = 1'b1;
    for (int i = 0; i < 10; i++) do_tick();
    chk("walk_x", char_X, 52);
    chk("walk_y", char_Y, 400);
    chk("walk_state", mstate, WALK);
    chk("walk_facing", facing, 1);
    repeat (3) @(negedge clk);
    chk("walk_hold_x", char_X, 52);
    btn_right = 1'b0;
    do_tick();
    chk("walk_stop_state", mstate, IDLE);
    chk("walk_stop_x", char_X, 52);

    // Jump, then jump with extra presses while airborne
    run_jump(1'b0);
    run_jump(1'b1);

    // Left clamp at 0
    do_reset();
    btn_left = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      do_tick();
      if (i == 15) chk("left_x15", char_X, 2);
      if (i == 16) chk("left_x16", char_X, 0);
    end
    chk("left_x20", char_X, 0);
    chk("left_facing", facing, 0);
    chk("left_state", mstate, WALK);
    btn_left = 1'b0;

    // Right clamp at X_MAX
    btn_right = 1'b1;
    for (int i = 1; i <= 470; i++) begin
      do_tick();
      if (i == 463) chk("right_x463", char_X, 926);
      if (i == 464) chk("right_x464", char_X, 928);
    end
    chk("right_x470", char_X, 928);
    chk("right_facing", facing, 1);

    // Both directions held
    btn_left = 1'b1;
    for (int i = 0; i < 5; i++) do_tick();
    chk("both_x", char_X, 928);
    chk("both_state", mstate, IDLE);
    chk("both_facing", facing, 1);
    btn_right = 1'b0;
    do_tick();
    chk("leftface_x", char_X, 926);
    chk("leftface_facing", facing, 0);
    btn_left = 1'b0;

    // Reset together with a tick mid-jump
    do_reset();
    jump_pulse();
    do_tick();
    for (int i = 1; i <= 4; i++) do_tick();
    chk("rj_y4", char_Y, 358);
    btn_right = 1'b1;
    @(negedge clk); rst = 1'b1; frame_tick = 1'b1;
    @(negedge clk); rst = 1'b0; frame_tick = 1'b0;
    chk("rj_y", char_Y, 400);
    chk("rj_x", char_X, 32);
    chk("rj_state", mstate, IDLE);
    chk("rj_gnd", on_ground, 1);
    btn_right = 1'b0;
    do_tick();
    chk("rj_pending_clear", mstate, IDLE);
    chk("rj_after_y", char_Y, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
